// File: rtl/ps2_pkg.sv
// Shared constants and FSM encoding for the PS/2 keyboard receiver.
// Prefix bytes, frame length and receiver state type.
package ps2_pkg;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam int FRAME_LEN = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/ps2_sync_filt.sv
// Two-flop synchronizer, level glitch filter and falling-edge detector
// for the PS/2 clock pin.
module ps2_sync_filt #(
    parameter int FILT_CYC = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic fall
);

    localparam int CW = $clog2(FILT_CYC + 1);

    logic          s1;
    logic          s2;
    logic          filt;
    logic [CW-1:0] cnt;

    // filt follows s2 only after FILT_CYC consecutive differing samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            filt <= 1'b1;
            cnt  <= '0;
            fall <= 1'b0;
        end else begin
            s1   <= pin;
            s2   <= s1;
            fall <= 1'b0;
            if (s2 == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_CYC - 1)) begin
                filt <= s2;
                cnt  <= '0;
                fall <= filt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receive front end: deframes scancodes, folds E0/F0 prefixes.
// Define PS2_RX_FIFO_EN to queue codes in a FIFO_DEPTH-entry FIFO.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int TIMEOUT_US = 200,
    parameter int FILT_CYC   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_ext,
    output logic       code_brk,
    output logic       code_valid,
    input  logic       code_ack,
    output logic       err,
    output logic       overrun
);

    localparam int TO_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int TW     = $clog2(TO_CYC + 1);

    logic          fall;
    logic          data_m;
    logic          data_s;
    state_t        state;
    logic [3:0]    bitcnt;
    logic [9:0]    shreg;
    logic          ext_pend;
    logic          brk_pend;
    logic [TW-1:0] to_cnt;
    logic          good;
    logic          timeout;
    logic          emit;
    logic [9:0]    emit_word;

    ps2_sync_filt #(
        .FILT_CYC(FILT_CYC)
    ) u_clk_filt (
        .clk    (clk),
        .reset_n(reset_n),
        .pin    (ps2_clk),
        .fall   (fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_m <= 1'b1;
            data_s <= 1'b1;
        end else begin
            data_m <= ps2_data;
            data_s <= data_m;
        end
    end

    // shreg[7:0] data, [8] parity, [9] stop once ten bits are in
    assign good      = (^shreg[8:0]) & shreg[9];
    assign timeout   = (state == RECV) && !fall && (to_cnt == TW'(TO_CYC - 1));
    assign emit      = (state == CHECK) && good &&
                       (shreg[7:0] != BYTE_E0) && (shreg[7:0] != BYTE_F0);
    assign emit_word = {ext_pend, brk_pend, shreg[7:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bitcnt   <= '0;
            shreg    <= '0;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            to_cnt   <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (state != RECV || fall) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (fall && !data_s) begin
                        state  <= RECV;
                        bitcnt <= 4'd1;
                    end
                end
                RECV: begin
                    if (fall) begin
                        shreg  <= {data_s, shreg[9:1]};
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt == 4'(FRAME_LEN - 1)) begin
                            state <= CHECK;
                        end
                    end else if (timeout) begin
                        err      <= 1'b1;
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                        state    <= IDLE;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!good) begin
                        err      <= 1'b1;
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                    end else if (shreg[7:0] == BYTE_E0) begin
                        ext_pend <= 1'b1;
                    end else if (shreg[7:0] == BYTE_F0) begin
                        brk_pend <= 1'b1;
                    end else begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PS2_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = code_ack && !empty;
    // a full FIFO still accepts a push when the head leaves this cycle
    assign push  = emit && (!full || pop);

    assign {code_ext, code_brk, code} = mem[rd_ptr[AW-1:0]];
    assign code_valid = !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= emit_word;
                wr_ptr <= wr_ptr + 1'b1;
            end else if (emit) begin
                overrun <= 1'b1;
            end
        end
    end
`else
    logic unused_depth;
    assign unused_depth = (FIFO_DEPTH == 0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code       <= '0;
            code_ext   <= 1'b0;
            code_brk   <= 1'b0;
            code_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (code_ack) begin
                code_valid <= 1'b0;
            end
            if (emit) begin
                if (!code_valid || code_ack) begin
                    {code_ext, code_brk, code} <= emit_word;
                    code_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end
`endif

endmodule
